uart_tx_port: RTL and testbench

Memory-mapped serial transmit peripheral on the core's operand/data bus, alongside the simulated serial device and 7-segment display. It consumes core store cycles (rw/addr/data), buffers bytes in a small FIFO, and shifts them out as 8N1 frames on `txd`. Status is readable back over the same bus, so firmware can poll before writing.

---
 rtl/uart_tx_port_pkg.sv | 40 ++++
 rtl/uart_tx_port_if.sv | 16 +
 rtl/uart_tx_port_fifo_sync.sv | 69 ++++++
 rtl/uart_tx_port.sv | 159 +++++++++++++++
 tb/tb_uart_tx_port.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_port_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_port_pkg
//  Description : Shared register offsets, status bit indices and transmit
//                FSM state encoding for the memory-mapped UART transmitter.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_tx_port_pkg;

    // Register offsets relative to the block's base word address
    localparam logic [31:0] UART_TX_DATA = 32'd0;
    localparam logic [31:0] UART_TX_CTRL = 32'd1;

    // Bit positions inside the STATUS word
    localparam int UTX_FULL  = 0;
    localparam int UTX_EMPTY = 1;
    localparam int UTX_OVF   = 2;
    localparam int UTX_BUSY  = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } tx_state_t;

    // Assemble the four status flags at their documented bit positions
    function automatic logic [3:0] status_bits(input logic busy, input logic ovf,
                                               input logic empty, input logic full);
        logic [3:0] s;
        s            = '0;
        s[UTX_BUSY]  = busy;
        s[UTX_OVF]   = ovf;
        s[UTX_EMPTY] = empty;
        s[UTX_FULL]  = full;
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_port_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_port_if
//  Description : Core operand-bus decode signals (enable/rw/addr). The data
//                lines are bidirectional and stay a separate inout port.
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_port_if;
    logic        enable;
    logic        rw;
    logic [31:0] addr;

    modport master (output enable, output rw, output addr);
    modport slave  (input  enable, input  rw, input  addr);
endinterface
`default_nettype wire

// File: rtl/uart_tx_port_fifo_sync.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_sync
//  Description : Single-clock FIFO. Read data is the head entry and is valid
//                on the pop edge. A push to a full FIFO is accepted only when
//                a pop happens on the same edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_sync #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  wire logic                         clk,
    input  wire logic                         reset,
    input  wire logic                         i_push,
    input  wire logic                         i_pop,
    input  wire logic [WIDTH-1:0]             i_wdata,
    output logic      [WIDTH-1:0]             o_rdata,
    output logic                              o_full,
    output logic                              o_empty,
    output logic      [$clog2(DEPTH+1)-1:0]   o_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_pop_ok;
    logic             w_push_ok;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rd_ptr];
    assign w_pop_ok  = i_pop && !o_empty;
    assign w_push_ok = i_push && (!o_full || w_pop_ok);

    // Storage array: written on accepted pushes, never reset
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_port.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_port
//  Description : Memory-mapped 8N1 serial transmitter. Core stores push bytes
//                into a FIFO; a bit-timed FSM shifts them out on txd with
//                back-to-back frames when data is waiting. STATUS and FIFO
//                count are readable over the shared tri-state data bus.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_port
    import uart_tx_port_pkg::*;
#(
    parameter logic [31:0] BASE   = 32'h0000_0200,
    parameter int          DEPTH  = 8,
    parameter logic [15:0] CLKDIV = 16'd16
) (
    input  wire logic        clk,
    input  wire logic        reset,
    uart_tx_port_if.slave    bus,
    inout  wire logic [31:0] data,
    output logic             txd
);
    localparam int CW = $clog2(DEPTH + 1);

    tx_state_t     r_state;
    logic [15:0]   r_baud;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          r_txd;
    logic          r_ovf;

    logic          w_hit_data;
    logic          w_hit_ctrl;
    logic          w_push;
    logic          w_clr;
    logic          w_pop;
    logic          w_bit_end;
    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_count;
    logic [7:0]    w_fifo_rdata;
    logic          w_rd_en;
    logic [31:0]   w_rdval;

    // Bus decode; bus is ignored entirely while enable is low
    assign w_hit_data = bus.enable && (bus.addr == BASE + UART_TX_DATA);
    assign w_hit_ctrl = bus.enable && (bus.addr == BASE + UART_TX_CTRL);
    assign w_push     = w_hit_data && bus.rw;
    assign w_clr      = w_hit_ctrl && bus.rw;

    assign w_bit_end  = (r_baud == CLKDIV - 16'd1);
    // Pop from IDLE, or at the last stop-bit cycle so frames run back-to-back
    assign w_pop      = !w_empty &&
                        ((r_state == S_IDLE) || ((r_state == S_STOP) && w_bit_end));

    fifo_sync #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (data[7:0]),
        .o_rdata (w_fifo_rdata),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Read mux: STATUS at offset 0, zero-extended count at offset 1
    assign w_rd_en = !bus.rw && (w_hit_data || w_hit_ctrl);
    assign w_rdval = w_hit_data
                   ? {28'd0, status_bits(r_state != S_IDLE, r_ovf, w_empty, w_full)}
                   : 32'(w_count);
    assign data    = w_rd_en ? w_rdval : 'z;
    assign txd     = r_txd;

    // Sticky overflow: a dropped push outranks a same-edge clear
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovf <= 1'b0;
        end else if (w_push && w_full && !w_pop) begin
            r_ovf <= 1'b1;
        end else if (w_clr) begin
            r_ovf <= 1'b0;
        end
    end

    // Transmit FSM with bit timer; txd is registered alongside the state
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_baud  <= 16'd0;
            r_bit   <= 3'd0;
            r_shift <= 8'd0;
            r_txd   <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_txd <= 1'b1;
                    if (w_pop) begin
                        r_shift <= w_fifo_rdata;
                        r_state <= S_START;
                        r_baud  <= 16'd0;
                        r_txd   <= 1'b0;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_state <= S_DATA;
                        r_baud  <= 16'd0;
                        r_bit   <= 3'd0;
                        r_txd   <= r_shift[0];
                    end else begin
                        r_baud <= r_baud + 16'd1;
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_baud <= 16'd0;
                        if (r_bit == 3'd7) begin
                            r_state <= S_STOP;
                            r_txd   <= 1'b1;
                        end else begin
                            r_bit   <= r_bit + 3'd1;
                            r_shift <= {1'b0, r_shift[7:1]};
                            r_txd   <= r_shift[1];
                        end
                    end else begin
                        r_baud <= r_baud + 16'd1;
                    end
                end
                S_STOP: begin
                    if (w_bit_end) begin
                        r_baud <= 16'd0;
                        if (w_pop) begin
                            r_shift <= w_fifo_rdata;
                            r_state <= S_START;
                            r_txd   <= 1'b0;
                        end else begin
                            r_state <= S_IDLE;
                            r_txd   <= 1'b1;
                        end
                    end else begin
                        r_baud <= r_baud + 16'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_baud  <= 16'd0;
                    r_txd   <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_port.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_port
//  Description : Self-checking bench for uart_tx_port. Accepted bytes are
//                queued as expected frames; a txd monitor decodes each frame
//                and compares against the queue head.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_port;
    localparam logic [31:0] BASE  = 32'h0000_0200;
    localparam int          DEPTH = 8;
    localparam int          CD    = 4;
    localparam int          FL    = 10 * CD;

    logic        clk = 1'b0;
    logic        reset;
    wire  [31:0] data;
    logic        txd;
    logic [31:0] r_drv;
    logic        r_drv_en;

    uart_tx_port_if bus ();

    assign data = r_drv_en ? r_drv : 'z;
    pullup (data);

    uart_tx_port #(
        .BASE   (BASE),
        .DEPTH  (DEPTH),
        .CLKDIV (16'(CD))
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .data  (data),
        .txd   (txd)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         n_chk  = 0;
    int         n_pass = 0;
    logic [7:0] exp_q[$];
    int         fstart[$];
    int         n_frames  = 0;
    bit         mon_on    = 1'b0;
    bit         mon_abort = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic go_neg(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // Write that is sampled by the DUT on edge n
    task automatic wr_at(input int n, input logic [31:0] a, input logic [31:0] d);
        go_neg(n - 1);
        bus.enable = 1'b1; bus.rw = 1'b1; bus.addr = a;
        r_drv = d; r_drv_en = 1'b1;
        @(posedge clk);
        #1;
        bus.enable = 1'b0; bus.rw = 1'b0; r_drv_en = 1'b0;
    endtask

    // Combinational read during the cycle following edge n
    task automatic rd_at(input int n, input logic [31:0] a, output logic [31:0] v);
        go_neg(n);
        bus.enable = 1'b1; bus.rw = 1'b0; bus.addr = a; r_drv_en = 1'b0;
        #1;
        v = data;
        bus.enable = 1'b0;
    endtask

    task automatic drain();
        logic [31:0] v;
        int k;
        v = 32'd0;
        k = 0;
        while (k < 3000 && !(v == 32'h2 && exp_q.size() == 0)) begin
            rd_at(cyc + 1, BASE, v);
            k++;
        end
        chk("drain_status", v, 32'h2);
        chk("drain_queue", 32'(exp_q.size()), 32'd0);
    endtask

    // txd monitor: decode each frame from per-cycle samples
    initial begin
        logic [FL-1:0] s;
        logic [7:0]    b;
        logic          glitch;
        int            st;
        bit            ab;
        forever begin
            @(negedge clk);
            if (mon_on && !reset && txd === 1'b0 && !mon_abort) begin
                st   = cyc;
                ab   = 1'b0;
                s    = '0;
                s[0] = txd;
                for (int i = 1; i < FL && !ab; i++) begin
                    @(negedge clk);
                    if (mon_abort) ab = 1'b1;
                    else s[i] = txd;
                end
                if (ab) begin
                    mon_abort = 1'b0;
                end else begin
                    glitch = 1'b0;
                    for (int j = 0; j < 10; j++)
                        for (int i = 0; i < CD; i++)
                            if (s[j*CD+i] !== s[j*CD+CD/2]) glitch = 1'b1;
                    for (int j = 0; j < 8; j++) b[j] = s[(j+1)*CD + CD/2];
                    chk("frame_shape", {29'd0, glitch, s[CD/2], s[9*CD+CD/2]}, 32'h1);
                    chk("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
                    if (exp_q.size() > 0) chk("frame_byte", {24'd0, b}, {24'd0, exp_q.pop_front()});
                    fstart.push_back(st);
                    n_frames++;
                end
            end else if (mon_abort) begin
                mon_abort = 1'b0;
            end
        end
    end

    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] v;
        int E;
        reset = 1'b1; bus.enable = 1'b0; bus.rw = 1'b0; bus.addr = 32'd0;
        r_drv = 32'd0; r_drv_en = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        mon_on = 1'b1;
        chk("rst_txd", 32'(txd), 32'd1);
        rd_at(cyc, BASE, v);            chk("rst_status", v, 32'h2);
        rd_at(cyc, BASE + 1, v);        chk("rst_count", v, 32'd0);
        rd_at(cyc, BASE + 2, v);        chk("rst_unmapped_hiz", v, 32'hFFFF_FFFF);

        // Single 0x55 frame: latency, status sequencing, idle afterwards
        fstart.delete();
        E = cyc + 2;
        rd_at(E - 1, BASE, v);          chk("t1_status_pre", v, 32'h2);
        wr_at(E, BASE, 32'h55); exp_q.push_back(8'h55);
        rd_at(E, BASE, v);              chk("t1_status_queued", v, 32'h0);
        rd_at(E + 1, BASE, v);          chk("t1_status_busy", v, 32'hA);
        rd_at(E + 40, BASE, v);         chk("t1_status_stop", v, 32'hA);
        rd_at(E + 41, BASE, v);         chk("t1_status_done", v, 32'h2);
        drain();
        chk("t1_start_cycle", 32'(fstart[0]), 32'(E + 1));

        // Three bytes back-to-back: contiguous frames, count at each frame
        fstart.delete();
        E = cyc + 2;
        wr_at(E,     BASE, 32'h01); exp_q.push_back(8'h01);
        wr_at(E + 1, BASE, 32'h80); exp_q.push_back(8'h80);
        wr_at(E + 2, BASE, 32'hFF); exp_q.push_back(8'hFF);
        rd_at(E + 20,  BASE + 1, v);    chk("t2_count_f1", v, 32'd2);
        rd_at(E + 60,  BASE + 1, v);    chk("t2_count_f2", v, 32'd1);
        rd_at(E + 100, BASE + 1, v);    chk("t2_count_f3", v, 32'd0);
        drain();
        chk("t2_start0", 32'(fstart[0]), 32'(E + 1));
        chk("t2_gap1", 32'(fstart[1] - fstart[0]), 32'(FL));
        chk("t2_gap2", 32'(fstart[2] - fstart[1]), 32'(FL));

        // Overflow, clear, then a push coinciding with the STOP->START pop
        fstart.delete();
        E = cyc + 2;
        for (int i = 0; i < 10; i++) begin
            wr_at(E + i, BASE, 32'(8'h10 + i));
            if (i < 9) exp_q.push_back(8'(8'h10 + i));
        end
        rd_at(E + 9, BASE, v);          chk("t3_status_ovf", v, 32'hD);
        rd_at(E + 9, BASE + 1, v);      chk("t3_count_full", v, 32'd8);
        wr_at(E + 10, BASE + 1, 32'h0);
        rd_at(E + 10, BASE, v);         chk("t3_status_clr", v, 32'h9);
        wr_at(E + 41, BASE, 32'hC3); exp_q.push_back(8'hC3);
        rd_at(E + 41, BASE + 1, v);     chk("t3_count_coincide", v, 32'd8);
        rd_at(E + 41, BASE, v);         chk("t3_status_coincide", v, 32'h9);
        drain();
        chk("t3_contiguous", 32'(fstart[9] - fstart[0]), 32'(9 * FL));

        // Reset during data bit 3 aborts the frame and empties the FIFO
        E = cyc + 2;
        wr_at(E, BASE, 32'hE7); exp_q.push_back(8'hE7);
        go_neg(E + 18);
        reset = 1'b1; mon_abort = 1'b1; exp_q.delete();
        @(posedge clk);
        #1 reset = 1'b0;
        chk("t4_txd_high", 32'(txd), 32'd1);
        rd_at(cyc, BASE + 1, v);        chk("t4_count", v, 32'd0);
        rd_at(cyc, BASE, v);            chk("t4_status", v, 32'h2);
        wr_at(cyc + 3, BASE, 32'hA5); exp_q.push_back(8'hA5);
        drain();

        // Disabled bus: write ignored, data stays released, frame unaffected
        E = cyc + 2;
        wr_at(E, BASE, 32'h3C); exp_q.push_back(8'h3C);
        go_neg(E + 10);
        bus.enable = 1'b0; bus.rw = 1'b1; bus.addr = BASE; r_drv = 32'h77; r_drv_en = 1'b1;
        @(posedge clk);
        #1;
        r_drv_en = 1'b0; bus.rw = 1'b0;
        #1;
        chk("t5_en0_hiz", data, 32'hFFFF_FFFF);
        rd_at(E + 12, BASE + 1, v);     chk("t5_en0_count", v, 32'd0);
        rd_at(E + 12, BASE, v);         chk("t5_en0_busy", v, 32'hA);
        drain();

        chk("frames_total", 32'(n_frames), 32'd16);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
